// File: rtl/mem_write_checker.sv
// mem_write_checker: watches the data-memory store port and checks it against
// a programmable table of NUM_CHECKS expected (address, data) stores. Stores
// that fall inside the scratch window [IGN_BASE, IGN_BASE+IGN_SIZE) are
// counted and otherwise ignored. The verdict (done/pass/fail) is registered
// and sticky until reset, so it can drive LEDs directly on an FPGA.
//
// Build option: define MWC_UNORDERED_EN to let entries match in any order,
// using a hit mask. Without it, entries must match in index order.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | classifying stores; cycle counter running towards timeout
// PASS  | every table entry matched; stores and counters frozen
// FAIL  | stray store (fail_code=1) or timeout (fail_code=2); frozen
module mem_write_checker #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned NUM_CHECKS     = 4,
    parameter int unsigned IGN_BASE       = 96,
    parameter int unsigned IGN_SIZE       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned CIDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int unsigned MC_W          = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] DataAdrM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              cfg_we,
    input  logic [CIDX_W-1:0] cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [MC_W-1:0]   match_count,
    output logic [15:0]       ignore_count
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    // Window bounds one bit wider than the address so the top never wraps.
    localparam logic [ADDR_W:0] IGN_LO  = (ADDR_W+1)'(IGN_BASE);
    localparam logic [ADDR_W:0] IGN_HI  = IGN_LO + (ADDR_W+1)'(IGN_SIZE);
    localparam logic [31:0]     TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [ADDR_W-1:0] exp_addr [NUM_CHECKS];
    logic [DATA_W-1:0] exp_data [NUM_CHECKS];
    logic [31:0]       cyc_cnt;

`ifdef MWC_UNORDERED_EN
    logic [NUM_CHECKS-1:0] hit_mask;
    logic [NUM_CHECKS-1:0] hit_onehot;
`else
    logic [CIDX_W-1:0]     ptr;
`endif

    logic              hit;
    logic              last_hit;
    logic              in_ign;
    logic              cfg_ok;
    logic              timeout_now;
    logic [ADDR_W:0]   addr_ext;

    // Classify the current store against the table and the ignore window.
    always_comb begin
        hit      = 1'b0;
        last_hit = 1'b0;
`ifdef MWC_UNORDERED_EN
        hit_onehot = '0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (!hit && !hit_mask[i] &&
                DataAdrM == exp_addr[i] && WriteDataM == exp_data[i]) begin
                hit           = 1'b1;
                hit_onehot[i] = 1'b1;
            end
        end
        last_hit = ((hit_mask | hit_onehot) == '1);
`else
        hit      = (DataAdrM == exp_addr[ptr]) && (WriteDataM == exp_data[ptr]);
        last_hit = (match_count == MC_W'(NUM_CHECKS - 1));
`endif
        addr_ext    = {1'b0, DataAdrM};
        in_ign      = (IGN_SIZE != 0) && (addr_ext >= IGN_LO) && (addr_ext < IGN_HI);
        cfg_ok      = (32'(cfg_idx) < NUM_CHECKS);
        timeout_now = (TIMEOUT_CYCLES != 0) && (cyc_cnt == TO_LAST);
    end

    // Table writes, store classification, counters and the verdict FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= 2'd0;
            fail_addr    <= '0;
            fail_data    <= '0;
            match_count  <= '0;
            ignore_count <= '0;
            cyc_cnt      <= '0;
`ifdef MWC_UNORDERED_EN
            hit_mask     <= '0;
`else
            ptr          <= '0;
`endif
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_addr[i] <= '0;
                exp_data[i] <= '0;
            end
        end else begin
            // The store comparison above reads the old entry, so a write to
            // the entry being matched only affects later stores.
            if (cfg_we && cfg_ok) begin
                exp_addr[cfg_idx] <= cfg_addr;
                exp_data[cfg_idx] <= cfg_data;
            end

            if (state == S_RUN) begin
                cyc_cnt <= cyc_cnt + 32'd1;

                if (MemWriteM && hit) begin
                    match_count <= match_count + MC_W'(1);
`ifdef MWC_UNORDERED_EN
                    hit_mask    <= hit_mask | hit_onehot;
`else
                    ptr         <= ptr + CIDX_W'(1);
`endif
                end else if (MemWriteM && in_ign) begin
                    if (ignore_count != 16'hFFFF) begin
                        ignore_count <= ignore_count + 16'd1;
                    end
                end

                // A completing match beats a coincident timeout; a stray
                // store beats it too and reports itself as the cause.
                if (MemWriteM && hit && last_hit) begin
                    state <= S_PASS;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end else if (MemWriteM && !hit && !in_ign) begin
                    state     <= S_FAIL;
                    done      <= 1'b1;
                    fail      <= 1'b1;
                    fail_code <= 2'd1;
                    fail_addr <= DataAdrM;
                    fail_data <= WriteDataM;
                end else if (timeout_now) begin
                    state     <= S_FAIL;
                    done      <= 1'b1;
                    fail      <= 1'b1;
                    fail_code <= 2'd2;
                    fail_addr <= '0;
                    fail_data <= '0;
                end
            end
        end
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised store-sequence checker for the pipelined RISC-V core's data-memory write port (MemWriteM/DataAdrM/WriteDataM).
- Holds a programmable table of NUM_CHECKS expected (address, data) stores and silently ignores stores inside one scratch window.
- Flags pass when every expected store has occurred, and fail on a stray store or timeout.
- Used in simulation and on FPGA, where done/pass drive LEDs in place of the bench's $display/$stop.

Parameters:
- DATA_W, 32, data bus width
- ADDR_W, 32, address bus width
- NUM_CHECKS, 4, number of expected-store table entries; must be >= 1
- IGN_BASE, 96, first byte address of the ignore window
- IGN_SIZE, 4, ignore window size in bytes; 0 disables the window
- TIMEOUT_CYCLES, 1000, cycles from reset release to fail; 0 disables the timeout

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- MemWriteM  in  1  store strobe, one store per cycle while high
- DataAdrM  in  ADDR_W  store address
- WriteDataM  in  DATA_W  store data
- cfg_we  in  1  table write enable
- cfg_idx  in  clog2(NUM_CHECKS) (min 1)  table entry index
- cfg_addr  in  ADDR_W  expected address
- cfg_data  in  DATA_W  expected data
- done  out  1  verdict reached (pass or fail)
- pass  out  1  all entries matched
- fail  out  1  stray store or timeout
- fail_code  out  2  0 none, 1 stray store, 2 timeout
- fail_addr  out  ADDR_W  address of the offending store
- fail_data  out  DATA_W  data of the offending store
- match_count  out  clog2(NUM_CHECKS+1)  number of entries matched so far
- ignore_count  out  16  ignored stores, saturates at 0xFFFF

Behaviour:
- Reset:
  - done=pass=fail=0, fail_code=0, fail_addr=fail_data=0, match_count=0, ignore_count=0.
  - Table entries are cleared to 0 and the cycle counter to 0.
  - The FSM goes to RUN.
  - Reset asserted in any state, including PASS or FAIL, restarts checking from scratch.
- FSM states: RUN, PASS, FAIL. PASS and FAIL are sticky until reset.
- In RUN, each cycle with MemWriteM=1 is classified with the following priority:
  1. Match: DataAdrM==exp_addr[ptr] and WriteDataM==exp_data[ptr].
     - ptr and match_count increment.
     - If match_count becomes NUM_CHECKS, go to PASS on the next edge.
  2. Ignore: IGN_SIZE!=0 and IGN_BASE <= DataAdrM < IGN_BASE+IGN_SIZE, compared unsigned in ADDR_W+1 bits so the window never wraps.
     - ignore_count increments, saturating.
  3. Otherwise, stray store: capture DataAdrM/WriteDataM into fail_addr/fail_data, set fail_code=1, go to FAIL.
- A match takes priority over the ignore window when an expected address lies inside it.
- Ordering: entries must match in index order 0..NUM_CHECKS-1 (ordered mode).
- Timeout:
  - The cycle counter increments every RUN cycle.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no pass, go to FAIL with fail_code=2 and fail_addr/fail_data=0.
  - If a store completes the final match in the same cycle as the timeout, the result is PASS.
  - If a stray store occurs in the same cycle as the timeout, the result is FAIL with fail_code=1.
- Verdict latency: done/pass/fail are registered and rise one cycle after the deciding store is sampled. pass and fail are never both 1.
- Stores arriving in PASS or FAIL are ignored, and no counters change.
- cfg writes:
  - Accepted in any state.
  - If cfg_idx equals ptr in the same cycle as a store, the comparison uses the pre-write (old) entry value.
  - cfg_idx >= NUM_CHECKS is dropped.

Optional Feature:
- Macro: MWC_UNORDERED_EN.
- Defined: entries match in any order.
  - A NUM_CHECKS-bit hit mask replaces ptr.
  - A store matches the lowest-index unhit entry with equal address and data, then sets that bit.
  - An entry can match only once, so duplicate stores of an already-hit entry fall to the ignore/stray rules.
  - PASS when the mask is all ones; match_count = popcount(mask).
- Undefined: ordered matching as described above; no mask logic is synthesised.

Test Plan:
- NUM_CHECKS=1, entry0=(100,25):
  - Stores (96,7), (96,9), (100,25) -> ignore_count=2, pass=1 one cycle after the (100,25) store, fail_code=0.
- Stray store, entry0=(100,25):
  - Store (104,25) -> fail=1, fail_code=1, fail_addr=104, fail_data=25; a later (100,25) leaves pass=0.
- NUM_CHECKS=2, entries (100,25),(104,3), ordered build:
  - Stores (104,3) then (100,25) -> fail at (104,3).
  - Same stimulus in the MWC_UNORDERED_EN build -> pass after the second store, match_count=2.
- TIMEOUT_CYCLES=50, no stores -> fail=1, fail_code=2 exactly 50 cycles after reset release.
- Reset mid-run:
  - Match 1 of 2 entries, assert reset for one cycle -> all outputs 0 and table cleared.
  - Reprogram the table and replay both stores -> pass.
- Same-cycle config overwrite:
  - cfg_we to entry0 with (100,99) in the same cycle as store (100,25), old entry (100,25) -> match counted (old value used).
  - Next store (100,25) against NUM_CHECKS=2, where entry1 is unmatched -> handled as a stray store unless it falls in the ignore window.
